alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Parametrised, registered successor to the basic-computer combinational ALU. It executes the existing accumulator micro-operations (AND, ADD, LDA, CMA, CME, CIR, CIL, INP) plus new SUB and multi-cycle unsigned MUL. Operation is under a start/done handshake. It sits between the AC/DR/E/INPR registers and the control sequencer; the sequencer holds its timing state until `done`.

## Interface
- `WIDTH`, default 16: data path width (AC, DR, result); legal range 4–32.
- `INW`, default 8: input-register width; must satisfy INW < WIDTH.
- `clk`  in  1  rising-edge clock. One clock, single domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted only on a rising edge where `busy`=0.
- `alu_code`  in  4  operation select, sampled at accept.
- `ac_in`  in  WIDTH  accumulator operand, sampled at accept.
- `dr_in`  in  WIDTH  data-register operand, sampled at accept.
- `e_in`  in  1  current E flag, sampled at accept.
- `inpr_in`  in  INW  input-register character, sampled at accept.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: result, ac_we and e_we are valid.
- `result`  out  WIDTH  registered result; holds between operations.
- `e_out`  out  1  registered new E value.
- `ac_we`  out  1  AC write enable, asserted only with `done`.
- `e_we`  out  1  E write enable, asserted only with `done`.

## Operation
- Codes (A=ac_in, D=dr_in, E=e_in, all captured at accept):
  - 0001 AND: A&D; ac_we=1, e_we=0.
  - 0010 ADD: {E',R}=A+D; ac_we=1, e_we=1.
  - 0011 LDA: D; ac_we=1, e_we=0.
  - 0100 SUB: {E',R}=A+~D+1 (E'=1 means no borrow); ac_we=1, e_we=1.
  - 0101 MUL: unsigned A×D. R = low WIDTH bits; E'=1 if the high WIDTH bits are nonzero (overflow). ac_we=1, e_we=1.
  - 1001 CMA: ~A; ac_we=1, e_we=0.
  - 1010 CME: E'=~E; ac_we=0, e_we=1; result unchanged.
  - 1011 CIR: R={E,A[WIDTH-1:1]}, E'=A[0]; both we=1.
  - 1100 CIL: R={A[WIDTH-2:0],E}, E'=A[WIDTH-1]; both we=1.
  - 1101 INP: R={A[WIDTH-1:INW],inpr_in}; ac_we=1, e_we=0.
  - any other code: `done` pulses; ac_we=0, e_we=0; result and e_out unchanged.
- FSM states:
  - IDLE → EXEC on accept.
  - EXEC → IDLE after one cycle for all codes except MUL.
  - MUL: IDLE → MULT (busy=1) → IDLE.
- MULT: shift-add, one multiplier bit per cycle, LSB first, into a 2·WIDTH accumulator; a bit counter runs from WIDTH down to 0.
- Operands are latched at accept; input changes during MULT have no effect.
- `start` while busy=1 is ignored (not queued, no error).
- When ac_we/e_we are 0, result/e_out hold their prior values.

## Timing
- Reset (async assert, sync release): state IDLE; busy=0, done=0, ac_we=0, e_we=0, result=0, e_out=0, counter=0.
- Accept on edge T. Single-cycle ops: done/we/result valid in the cycle after T (latency 1), pulse width 1.
- MUL accept at edge T:
  - busy=1 for exactly WIDTH cycles following T.
  - On edge T+WIDTH+1, busy falls and done/we rise.
  - Latency is WIDTH+1 (17 for WIDTH=16).
- `done` and `busy` are never high in the same cycle.
- A new start may be accepted in the cycle where done=1 (back-to-back ops, no bubble).
- Reset asserted mid-MULT: immediate return to reset values; no done is produced for the aborted operation.
- ADD/SUB carry: bit WIDTH of the (WIDTH+1)-bit sum. All arithmetic is unsigned and wraps modulo 2^WIDTH.

## Test plan
- ADD: A=FFFF, D=0001 → result 0000, e_out=1, ac_we=e_we=1, done one cycle after accept.
- SUB:
  - A=0005, D=0007 → result FFFE, e_out=0.
  - A=0007, D=0005 → result 0002, e_out=1.
- MUL:
  - A=0123, D=0045 → result 4E6F, e_out=0; busy high 16 cycles, done at accept+17.
  - A=0100, D=0100 → result 0000, e_out=1.
- Rotates and INP, with E=1, A=8001:
  - CIL → result 0003, e_out=1.
  - CIR → result C000, e_out=1.
  - INP with inpr=5A, A=12FF → result 125A, e_we=0.
- Handshake:
  - start during MUL busy with ADD code → ignored; MUL result unaffected; exactly one done.
  - Undefined code 0111 → done=1, we=0, result unchanged.
- Reset and parameters:
  - rst_n low at cycle 8 of MUL → all outputs reset immediately, no done; the next ADD works normally.
  - Repeat MUL/ADD at WIDTH=8, INW=4: 0F×11 → FF, E=0.

Source files
------------

// File: rtl/alu_seq_unit.sv
// alu_seq_unit
//   Registered accumulator ALU for the basic computer. Executes the classic
//   accumulator micro-operations plus SUB and a multi-cycle shift-add unsigned
//   MUL, under a start/done handshake.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, accepted only while the unit is idle
//   alu_code  operation select (sampled at accept)
//   ac_in     accumulator operand (sampled at accept)
//   dr_in     data-register operand (sampled at accept)
//   e_in      current E flag (sampled at accept)
//   inpr_in   input-register character (sampled at accept)
//   busy      multi-cycle multiply in progress
//   done      one-cycle pulse: result / e_out / write enables valid
//   result    registered result, holds between operations
//   e_out     registered new E value
//   ac_we     AC write enable (only with done)
//   e_we      E write enable (only with done)
module alu_seq_unit #(
  parameter int WIDTH = 16,
  parameter int INW   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_code,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] dr_in,
  input  logic             e_in,
  input  logic [INW-1:0]   inpr_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             e_out,
  output logic             ac_we,
  output logic             e_we
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LDA = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_CMA = 4'b1001;
  localparam logic [3:0] OP_CME = 4'b1010;
  localparam logic [3:0] OP_CIR = 4'b1011;
  localparam logic [3:0] OP_CIL = 4'b1100;
  localparam logic [3:0] OP_INP = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MULT = 2'd2
  } state_t;

  state_t             state_reg;
  logic [3:0]         code_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   d_reg;
  logic               e_reg;
  logic [INW-1:0]     inpr_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [CW-1:0]      count_reg;

  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               e_out_reg;
  logic               ac_we_reg;
  logic               e_we_reg;

  // Single-cycle datapath, evaluated from the operands latched at accept.
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   exec_r;
  logic               exec_e;
  logic               exec_acwe;
  logic               exec_ewe;

  assign sum_w  = {1'b0, a_reg} + {1'b0, d_reg};
  // Carry out of A + ~D + 1 is the "no borrow" flag.
  assign diff_w = {1'b0, a_reg} + {1'b0, ~d_reg} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    exec_r    = result_reg;
    exec_e    = e_out_reg;
    exec_acwe = 1'b0;
    exec_ewe  = 1'b0;
    case (code_reg)
      OP_AND: begin
        exec_r    = a_reg & d_reg;
        exec_acwe = 1'b1;
      end
      OP_ADD: begin
        exec_r    = sum_w[WIDTH-1:0];
        exec_e    = sum_w[WIDTH];
        exec_acwe = 1'b1;
        exec_ewe  = 1'b1;
      end
      OP_LDA: begin
        exec_r    = d_reg;
        exec_acwe = 1'b1;
      end
      OP_SUB: begin
        exec_r    = diff_w[WIDTH-1:0];
        exec_e    = diff_w[WIDTH];
        exec_acwe = 1'b1;
        exec_ewe  = 1'b1;
      end
      OP_CMA: begin
        exec_r    = ~a_reg;
        exec_acwe = 1'b1;
      end
      OP_CME: begin
        exec_e    = ~e_reg;
        exec_ewe  = 1'b1;
      end
      OP_CIR: begin
        exec_r    = {e_reg, a_reg[WIDTH-1:1]};
        exec_e    = a_reg[0];
        exec_acwe = 1'b1;
        exec_ewe  = 1'b1;
      end
      OP_CIL: begin
        exec_r    = {a_reg[WIDTH-2:0], e_reg};
        exec_e    = a_reg[WIDTH-1];
        exec_acwe = 1'b1;
        exec_ewe  = 1'b1;
      end
      OP_INP: begin
        exec_r    = {a_reg[WIDTH-1:INW], inpr_reg};
        exec_acwe = 1'b1;
      end
      default: begin
        // Undefined codes (and MUL, which never reaches EXEC): no writes.
      end
    endcase
  end

  // Shift-add step. The low half of prod_reg starts as the multiplier and is
  // consumed LSB first while the partial product grows in from the top.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;

  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                   + (prod_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
  assign prod_next = {mul_sum, prod_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      code_reg   <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      e_reg      <= 1'b0;
      inpr_reg   <= '0;
      prod_reg   <= '0;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      e_out_reg  <= 1'b0;
      ac_we_reg  <= 1'b0;
      e_we_reg   <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      ac_we_reg <= 1'b0;
      e_we_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            code_reg  <= alu_code;
            a_reg     <= ac_in;
            d_reg     <= dr_in;
            e_reg     <= e_in;
            inpr_reg  <= inpr_in;
            prod_reg  <= {{WIDTH{1'b0}}, dr_in};
            count_reg <= CW'(WIDTH);
            state_reg <= (alu_code == OP_MUL) ? MULT : EXEC;
          end
        end
        EXEC: begin
          done_reg  <= 1'b1;
          ac_we_reg <= exec_acwe;
          e_we_reg  <= exec_ewe;
          if (exec_acwe) result_reg <= exec_r;
          if (exec_ewe)  e_out_reg  <= exec_e;
          state_reg <= IDLE;
        end
        MULT: begin
          if (count_reg != '0) begin
            // busy rises on the first step edge and stays for WIDTH cycles.
            prod_reg  <= prod_next;
            count_reg <= count_reg - 1'b1;
            busy_reg  <= 1'b1;
          end else begin
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            ac_we_reg  <= 1'b1;
            e_we_reg   <= 1'b1;
            result_reg <= prod_reg[WIDTH-1:0];
            e_out_reg  <= |prod_reg[2*WIDTH-1:WIDTH];
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign e_out  = e_out_reg;
  assign ac_we  = ac_we_reg;
  assign e_we   = e_we_reg;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        start;
  logic [3:0]  alu_code;
  logic [15:0] ac, dr;
  logic        e_in;
  logic [7:0]  inpr;
  logic        busy16, done16, eout16, acwe16, ewe16;
  logic [15:0] result16;

  // 8-bit instance
  logic        start8;
  logic [3:0]  code8;
  logic [7:0]  ac8, dr8;
  logic        e8;
  logic [3:0]  inpr8;
  logic        busy8, done8, eout8, acwe8, ewe8;
  logic [7:0]  result8;

  alu_seq_unit #(.WIDTH(16), .INW(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_code(alu_code),
    .ac_in(ac), .dr_in(dr), .e_in(e_in), .inpr_in(inpr),
    .busy(busy16), .done(done16), .result(result16), .e_out(eout16),
    .ac_we(acwe16), .e_we(ewe16)
  );

  alu_seq_unit #(.WIDTH(8), .INW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .alu_code(code8),
    .ac_in(ac8), .dr_in(dr8), .e_in(e8), .inpr_in(inpr8),
    .busy(busy8), .done(done8), .result(result8), .e_out(eout8),
    .ac_we(acwe8), .e_we(ewe8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: straight arithmetic on integers.
  logic [15:0] mdl_r;
  logic        mdl_e;

  task automatic model(input logic [3:0] c, input logic [15:0] a, d, input logic ei,
                       input logic [7:0] ip, output logic acwe, output logic ewe);
    int unsigned ua, ud, s;
    longint unsigned p;
    ua = a; ud = d;
    acwe = 1'b0; ewe = 1'b0;
    case (c)
      4'd1:  begin mdl_r = 16'(ua & ud); acwe = 1; end
      4'd2:  begin s = ua + ud; mdl_r = 16'(s % 65536); mdl_e = (s > 65535); acwe = 1; ewe = 1; end
      4'd3:  begin mdl_r = d; acwe = 1; end
      4'd4:  begin s = (ua + 65536 - ud) % 65536; mdl_r = 16'(s); mdl_e = (ua >= ud); acwe = 1; ewe = 1; end
      4'd5:  begin p = longint'(ua) * longint'(ud); mdl_r = 16'(p % 65536); mdl_e = ((p / 65536) != 0); acwe = 1; ewe = 1; end
      4'd9:  begin mdl_r = 16'(65535 - ua); acwe = 1; end
      4'd10: begin mdl_e = !ei; ewe = 1; end
      4'd11: begin mdl_r = 16'((ei ? 32768 : 0) + ua / 2); mdl_e = (ua % 2) == 1; acwe = 1; ewe = 1; end
      4'd12: begin mdl_r = 16'((ua * 2) % 65536 + (ei ? 1 : 0)); mdl_e = (ua >= 32768); acwe = 1; ewe = 1; end
      4'd13: begin mdl_r = 16'((ua / 256) * 256 + ip); acwe = 1; end
      default: ;
    endcase
  endtask

  // One operation on the 16-bit unit: timing, handshake and outputs checked.
  task automatic run16(input string tag, input logic [3:0] c, input logic [15:0] a, d,
                       input logic ei, input logic [7:0] ip, input logic [15:0] xr,
                       input logic xe, xacwe, xewe);
    int lat, nbusy, both;
    @(negedge clk);
    start = 1'b1; alu_code = c; ac = a; dr = d; e_in = ei; inpr = ip;
    @(posedge clk);
    lat = -1; nbusy = 0; both = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        // Scramble operands after accept; they must already be latched.
        start = 1'b0; ac = ~a; dr = ~d; e_in = ~ei; inpr = ~ip; alu_code = 4'b0010;
      end
      if (busy16) nbusy++;
      if (busy16 && done16) both++;
      if (done16) begin lat = cyc; break; end
    end
    check({tag, " latency"}, 64'(lat), (c == 4'd5) ? 64'd17 : 64'd1);
    check({tag, " busy_cycles"}, 64'(nbusy), (c == 4'd5) ? 64'd16 : 64'd0);
    check({tag, " busy_and_done"}, 64'(both), 64'd0);
    check({tag, " result"}, 64'(result16), 64'(xr));
    check({tag, " e_out"}, 64'(eout16), 64'(xe));
    check({tag, " ac_we"}, 64'(acwe16), 64'(xacwe));
    check({tag, " e_we"}, 64'(ewe16), 64'(xewe));
    @(negedge clk);
    check({tag, " done_width"}, 64'(done16), 64'd0);
    $display("op %s code=%h A=%h D=%h E=%0d -> result=%h e=%0d we=%0d%0d lat=%0d",
             tag, c, a, d, ei, result16, eout16, xacwe, xewe, lat);
  endtask

  task automatic run8(input string tag, input logic [3:0] c, input logic [7:0] a, d,
                      input logic [7:0] xr, input logic xe, input int xlat);
    int lat;
    @(negedge clk);
    start8 = 1'b1; code8 = c; ac8 = a; dr8 = d; e8 = 1'b0; inpr8 = 4'h0;
    @(posedge clk);
    lat = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin start8 = 1'b0; ac8 = 8'h00; dr8 = 8'h00; end
      if (done8) begin lat = cyc; break; end
    end
    check({tag, " latency"}, 64'(lat), 64'(xlat));
    check({tag, " result"}, 64'(result8), 64'(xr));
    check({tag, " e_out"}, 64'(eout8), 64'(xe));
    check({tag, " we"}, 64'({acwe8, ewe8}), 64'd3);
    @(negedge clk);
    $display("op8 %s code=%h A=%h D=%h -> result=%h e=%0d lat=%0d", tag, c, a, d, result8, eout8, lat);
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [15:0] a, d;
    logic        e;
    logic [7:0]  ip;
    logic [15:0] xr;
    logic        xe, xacwe, xewe;
  } vec_t;

  vec_t tbl[13];
  logic [3:0] codes[13];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    logic acw, ew;
    logic [3:0]  rc;
    logic [15:0] ra, rd;
    logic        re;
    logic [7:0]  rip;

    tbl[0]  = '{4'b0010, 16'hFFFF, 16'h0001, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1}; // ADD wrap
    tbl[1]  = '{4'b0100, 16'h0005, 16'h0007, 1'b0, 8'h00, 16'hFFFE, 1'b0, 1'b1, 1'b1}; // SUB borrow
    tbl[2]  = '{4'b0100, 16'h0007, 16'h0005, 1'b0, 8'h00, 16'h0002, 1'b1, 1'b1, 1'b1}; // SUB
    tbl[3]  = '{4'b0101, 16'h0123, 16'h0045, 1'b0, 8'h00, 16'h4E6F, 1'b0, 1'b1, 1'b1}; // MUL
    tbl[4]  = '{4'b0101, 16'h0100, 16'h0100, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b1}; // MUL ovf
    tbl[5]  = '{4'b1100, 16'h8001, 16'h0000, 1'b1, 8'h00, 16'h0003, 1'b1, 1'b1, 1'b1}; // CIL
    tbl[6]  = '{4'b1011, 16'h8001, 16'h0000, 1'b1, 8'h00, 16'hC000, 1'b1, 1'b1, 1'b1}; // CIR
    tbl[7]  = '{4'b1101, 16'h12FF, 16'h0000, 1'b0, 8'h5A, 16'h125A, 1'b1, 1'b1, 1'b0}; // INP
    tbl[8]  = '{4'b0111, 16'hAAAA, 16'h5555, 1'b0, 8'h00, 16'h125A, 1'b1, 1'b0, 1'b0}; // undefined
    tbl[9]  = '{4'b0001, 16'h0F0F, 16'h00FF, 1'b0, 8'h00, 16'h000F, 1'b1, 1'b1, 1'b0}; // AND
    tbl[10] = '{4'b0011, 16'h0000, 16'h1234, 1'b0, 8'h00, 16'h1234, 1'b1, 1'b1, 1'b0}; // LDA
    tbl[11] = '{4'b1001, 16'h00FF, 16'h0000, 1'b0, 8'h00, 16'hFF00, 1'b1, 1'b1, 1'b0}; // CMA
    tbl[12] = '{4'b1010, 16'h0000, 16'h0000, 1'b1, 8'h00, 16'hFF00, 1'b0, 1'b0, 1'b1}; // CME

    codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd0, 4'd7, 4'd15};

    rst_n = 1'b0;
    start = 1'b0; alu_code = 4'h0; ac = '0; dr = '0; e_in = 1'b0; inpr = '0;
    start8 = 1'b0; code8 = 4'h0; ac8 = '0; dr8 = '0; e8 = 1'b0; inpr8 = '0;
    repeat (3) @(negedge clk);
    check("reset outputs16", 64'({busy16, done16, result16, eout16, acwe16, ewe16}), 64'd0);
    check("reset outputs8", 64'({busy8, done8, result8, eout8, acwe8, ewe8}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      run16($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].ip,
            tbl[i].xr, tbl[i].xe, tbl[i].xacwe, tbl[i].xewe);
    end
    mdl_r = 16'hFF00; mdl_e = 1'b0;

    // Randomised operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rc  = codes[$urandom_range(0, 12)];
      ra  = 16'($urandom); rd = 16'($urandom);
      re  = 1'($urandom); rip = 8'($urandom);
      model(rc, ra, rd, re, rip, acw, ew);
      run16($sformatf("rnd%0d", i), rc, ra, rd, re, rip, mdl_r, mdl_e, acw, ew);
    end

    // start while MUL is busy must be ignored: one done, MUL result intact.
    @(negedge clk);
    start = 1'b1; alu_code = 4'b0101; ac = 16'h00FF; dr = 16'h0101; e_in = 1'b0;
    @(posedge clk);
    ndone = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 0)  start = 1'b0;
      if (cyc == 3)  begin start = 1'b1; alu_code = 4'b0010; ac = 16'h0001; dr = 16'h0001; end
      if (cyc == 12) start = 1'b0;
      if (done16) ndone++;
    end
    check("busy_start done_count", 64'(ndone), 64'd1);
    check("busy_start result", 64'(result16), 64'hFFFF);
    check("busy_start e_out", 64'(eout16), 64'd0);
    $display("op busy_start MUL 00FF*0101 with ADD during busy -> result=%h dones=%0d", result16, ndone);

    // Reset during MULT: outputs clear immediately, no done afterwards.
    @(negedge clk);
    start = 1'b1; alu_code = 4'b0101; ac = 16'h0123; dr = 16'h0045;
    @(posedge clk);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
    end
    check("mid_mul busy_before_reset", 64'(busy16), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_mul reset outputs", 64'({busy16, done16, result16, eout16, acwe16, ewe16}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    check("mid_mul no_done", 64'(ndone), 64'd0);
    $display("op reset_mid_mul -> dones_after=%0d", ndone);
    run16("post_reset_add", 4'b0010, 16'h1234, 16'h4321, 1'b0, 8'h00, 16'h5555, 1'b0, 1'b1, 1'b1);

    // Narrow instance.
    run8("w8_mul", 4'b0101, 8'h0F, 8'h11, 8'hFF, 1'b0, 9);
    run8("w8_add", 4'b0010, 8'hF0, 8'h20, 8'h10, 1'b1, 1);
    run8("w8_sub", 4'b0100, 8'h03, 8'h05, 8'hFE, 1'b0, 1);
    run8("w8_mul_ovf", 4'b0101, 8'h10, 8'h10, 8'h00, 1'b1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
